icache: RTL and testbench

Direct-mapped, read-only instruction cache. It is the responder for the instruction fetcher's fetch handshake and sits between the fetch stage and the memory controller. Hits return one cycle after the request is sampled; misses fetch one 32-bit word from the memory controller, fill the line, then respond. A mispredict flush (`jump_wrong`) cancels the response to any in-flight request, but never the memory transaction itself.

---
 rtl/icache.sv | 137 +++++++++++++
 tb/tb_icache.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one 32-bit word per line.
// Hits respond one cycle after the request is sampled. Misses issue a single
// word read to the memory controller, fill the line, then respond. A
// mispredict flush cancels the pending response but lets an in-flight memory
// read finish (the controller cannot abort), filling the line silently.
module icache #(
  parameter int INDEX_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_wrong,
  input  logic        fetch_enable,
  input  logic [31:0] fetch_addr,
  output logic [31:0] instr_out,
  output logic        fetch_success,
  output logic        mem_enable,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        mem_success
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MISS,
    S_DRAIN,
    S_RESP
  } state_e;

  state_e                  state_q;
  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [31:0]             data_mem [LINES];
  logic [31:0]             instr_q;
  logic [31:0]             mem_addr_q;
  logic                    fetch_success_q;
  logic                    mem_enable_q;

  logic [INDEX_BITS-1:0]   req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic [INDEX_BITS-1:0]   fill_idx;
  logic [TAG_W-1:0]        fill_tag;
  logic                    hit;
  logic                    fill_en;
  logic                    unused_addr_bits;

  // Request and fill address decomposition; the fill always targets the
  // latched miss address, which stays stable until the word returns.
  assign req_idx  = fetch_addr[INDEX_BITS+1:2];
  assign req_tag  = fetch_addr[31:INDEX_BITS+2];
  assign fill_idx = mem_addr_q[INDEX_BITS+1:2];
  assign fill_tag = mem_addr_q[31:INDEX_BITS+2];
  assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  // Byte offset within the word is irrelevant to a word-granular cache.
  assign unused_addr_bits = ^fetch_addr[1:0];

  // A returning word is written whenever a read is outstanding, flushed or not.
  assign fill_en = !rst && rdy && mem_success &&
                   ((state_q == S_MISS) || (state_q == S_DRAIN));

  // Tag and data storage.
  // NOTE: only the valid bits need a reset; tag/data arrays are left unreset so
  // they map onto plain RAM, and a stale entry is harmless while its valid is 0.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_data;
    end
  end

  // Control FSM with registered outputs and valid-bit bookkeeping.
  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      valid_q         <= '0;
      instr_q         <= '0;
      fetch_success_q <= 1'b0;
      mem_enable_q    <= 1'b0;
      mem_addr_q      <= '0;
    end else if (rdy) begin
      fetch_success_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (fetch_enable && !jump_wrong) begin
            if (hit) begin
              instr_q         <= data_mem[req_idx];
              fetch_success_q <= 1'b1;
              state_q         <= S_RESP;
            end else begin
              mem_addr_q   <= {fetch_addr[31:2], 2'b00};
              mem_enable_q <= 1'b1;
              state_q      <= S_MISS;
            end
          end
        end
        S_MISS: begin
          if (mem_success) begin
            valid_q[fill_idx] <= 1'b1;
            mem_enable_q      <= 1'b0;
            if (jump_wrong) begin
              state_q <= S_IDLE;
            end else begin
              instr_q         <= mem_data;
              fetch_success_q <= 1'b1;
              state_q         <= S_RESP;
            end
          end else if (jump_wrong) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (mem_success) begin
            valid_q[fill_idx] <= 1'b1;
            mem_enable_q      <= 1'b0;
            state_q           <= S_IDLE;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_out     = instr_q;
  assign fetch_success = fetch_success_q;
  assign mem_enable    = mem_enable_q;
  assign mem_addr      = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus pushes expected responses and memory
// addresses into queues, a monitor pops and compares them as the cache presents
// them, and a simple memory model answers reads after a fixed latency.
module tb_icache;

  localparam int MEM_LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        jump_wrong;
  logic        fetch_enable;
  logic [31:0] fetch_addr;
  logic [31:0] instr_out;
  logic        fetch_success;
  logic        mem_enable;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_success;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_resp_q[$];
  logic [31:0] exp_addr_q[$];

  icache #(.INDEX_BITS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .jump_wrong   (jump_wrong),
    .fetch_enable (fetch_enable),
    .fetch_addr   (fetch_addr),
    .instr_out    (instr_out),
    .fetch_success(fetch_success),
    .mem_enable   (mem_enable),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_success  (mem_success)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents: word at address a.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h0000_0090;
  endfunction

  // Memory controller model: answers a read MEM_LAT cycles after it starts.
  initial begin
    int cnt = 0;
    mem_success = 1'b0;
    mem_data    = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      mem_success = 1'b0;
      mem_data    = 32'hDEAD_BEEF;
      if (mem_enable && rdy && !rst) begin
        cnt++;
        if (cnt == MEM_LAT) begin
          mem_success = 1'b1;
          mem_data    = mem_word(mem_addr);
          cnt         = 0;
        end
      end else if (rdy) begin
        cnt = 0;
      end
    end
  end

  // Monitor: compares each newly presented response and memory request.
  initial begin
    logic        prev_fs = 1'b0;
    logic        prev_me = 1'b0;
    logic [31:0] cur_addr = '0;
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_fs = 1'b0;
        prev_me = 1'b0;
      end else begin
        if (fetch_success && prev_fs) check("fs_back_to_back_only_if_frozen", rdy, 1'b0);
        if (fetch_success && !(prev_fs && !rdy)) begin
          if (exp_resp_q.size() == 0) begin
            check("unexpected_fetch_success", 32'd0, 32'd1);
          end else begin
            e = exp_resp_q.pop_front();
            check("instr_out", instr_out, e);
          end
        end
        if (mem_enable && !prev_me) begin
          cur_addr = mem_addr;
          if (exp_addr_q.size() == 0) begin
            check("unexpected_mem_enable", 32'd0, 32'd1);
          end else begin
            e = exp_addr_q.pop_front();
            check("mem_addr", mem_addr, e);
          end
        end else if (mem_enable) begin
          check("mem_addr_stable", mem_addr, cur_addr);
        end
        prev_fs = fetch_success;
        prev_me = mem_enable;
      end
    end
  end

  // One fetch from request to consumed success, with latency and memory use checked.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] exp_instr, input bit miss);
    int n;
    bit saw_me;
    exp_resp_q.push_back(exp_instr);
    if (miss) exp_addr_q.push_back({addr[31:2], 2'b00});
    @(negedge clk);
    fetch_addr   = addr;
    fetch_enable = 1'b1;
    n      = 0;
    saw_me = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (mem_enable) saw_me = 1'b1;
    end while (!fetch_success && n < 50);
    fetch_enable = 1'b0;
    check("req_latency", n, miss ? MEM_LAT + 1 : 1);
    check("req_used_memory", {31'd0, saw_me}, {31'd0, miss});
  endtask

  // Waits (bounded) for mem_enable to be observed at a falling edge.
  task automatic wait_mem_enable(input string name);
    int n = 0;
    while (!mem_enable && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, mem_enable}, 32'd1);
  endtask

  initial begin
    bit [5:0] pat;
    rst          = 1'b1;
    rdy          = 1'b1;
    jump_wrong   = 1'b0;
    fetch_enable = 1'b0;
    fetch_addr   = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_fetch_success", {31'd0, fetch_success}, 32'd0);
    check("rst_instr_out", instr_out, 32'h0);
    check("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    rst = 1'b0;

    // Cold miss then hit.
    do_req(32'h0000_0000, 32'h0000_0093, 1'b1);
    do_req(32'h0000_0000, 32'h0000_0093, 1'b0);

    // Conflict eviction on index 1; byte offset bits are ignored on the last one.
    do_req(32'h0000_0004, 32'h0000_0097, 1'b1);
    do_req(32'h0000_0404, 32'h0000_0497, 1'b1);
    do_req(32'h0000_0006, 32'h0000_0097, 1'b1);

    // Held request from a stalled fetcher.
    do_req(32'h0000_0010, 32'h0000_0083, 1'b1);
    repeat (3) exp_resp_q.push_back(32'h0000_0083);
    @(negedge clk);
    fetch_addr   = 32'h0000_0010;
    fetch_enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[5-i] = fetch_success;
    end
    fetch_enable = 1'b0;
    check("held_pattern", {26'd0, pat}, {26'd0, 6'b101010});

    // Flush during a miss: read completes silently, line is filled.
    exp_addr_q.push_back(32'h0000_0020);
    @(negedge clk);
    fetch_addr   = 32'h0000_0020;
    fetch_enable = 1'b1;
    wait_mem_enable("flush_miss_started");
    @(negedge clk);
    jump_wrong   = 1'b1;
    fetch_enable = 1'b0;
    @(negedge clk);
    jump_wrong = 1'b0;
    check("flush_mem_enable_held", {31'd0, mem_enable}, 32'd1);
    @(negedge clk);
    check("flush_mem_enable_dropped", {31'd0, mem_enable}, 32'd0);
    check("flush_no_success", {31'd0, fetch_success}, 32'd0);
    repeat (3) @(negedge clk);
    do_req(32'h0000_0020, 32'h0000_00B3, 1'b0);

    // rdy low while in RESP freezes the pulse.
    exp_resp_q.push_back(32'h0000_0093);
    @(negedge clk);
    fetch_addr   = 32'h0000_0000;
    fetch_enable = 1'b1;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!fetch_success && n < 50);
      check("rdy_hit_latency", n, 1);
    end
    rdy          = 1'b0;
    fetch_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rdy_low_fs_held", {31'd0, fetch_success}, 32'd1);
      check("rdy_low_instr_held", instr_out, 32'h0000_0093);
    end
    rdy = 1'b1;
    @(negedge clk);
    check("rdy_back_fs_falls", {31'd0, fetch_success}, 32'd0);

    // Reset in the middle of a miss, then the cached address misses again.
    exp_addr_q.push_back(32'h0000_0030);
    @(negedge clk);
    fetch_addr   = 32'h0000_0030;
    fetch_enable = 1'b1;
    wait_mem_enable("rst_miss_started");
    rst          = 1'b1;
    fetch_enable = 1'b0;
    @(negedge clk);
    check("rst_mid_miss_mem_enable", {31'd0, mem_enable}, 32'd0);
    check("rst_mid_miss_fs", {31'd0, fetch_success}, 32'd0);
    rst = 1'b0;
    do_req(32'h0000_0000, 32'h0000_0093, 1'b1);

    repeat (5) @(negedge clk);
    check("resp_queue_drained", exp_resp_q.size(), 32'd0);
    check("addr_queue_drained", exp_addr_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
